// File: rtl/ram_sync_dp_if.sv
// Request/response bundle for ram_sync_dp.
// The requester uses the master modport and the RAM uses the slave modport.
interface ram_sync_dp_if #(
  parameter int ADDR_SIZE = 10,
  parameter int WORD_SIZE = 8
);
  logic                 cs;
  logic                 wr;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [WORD_SIZE-1:0] data_in;
  logic                 rd;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic [WORD_SIZE-1:0] data_out;
  logic                 rd_valid;
  logic                 busy;

  modport master (
    output cs, wr, wr_addr, data_in, rd, rd_addr,
    input  data_out, rd_valid, busy
  );

  modport slave (
    input  cs, wr, wr_addr, data_in, rd, rd_addr,
    output data_out, rd_valid, busy
  );
endinterface

// File: rtl/ram_sync_dp.sv
// Simple dual-port RAM with a registered read port and a self-clearing reset sequence.
// Optional macro RAM_BYPASS_EN: a same-address read/write collision returns the new data (write-first).
module ram_sync_dp #(
  parameter int ADDR_SIZE   = 10,
  parameter int WORD_SIZE   = 8,
  parameter int MEMORY_SIZE = 1024
) (
  input  logic         clk,
  input  logic         rst,
  ram_sync_dp_if.slave bus
);
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  // The pointer is one bit wider than the address so the terminal compare never wraps.
  localparam logic [ADDR_SIZE:0] LP_DEPTH = (ADDR_SIZE+1)'(MEMORY_SIZE);
  localparam logic [ADDR_SIZE:0] LP_LAST  = (ADDR_SIZE+1)'(MEMORY_SIZE - 1);
  localparam logic [ADDR_SIZE:0] LP_ONE   = (ADDR_SIZE+1)'(1);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [ADDR_SIZE:0]   r_clr_ptr;
  logic [WORD_SIZE-1:0] r_mem [MEMORY_SIZE];
  logic [WORD_SIZE-1:0] r_data_out;
  logic                 r_rd_valid;

  logic                 w_busy;
  logic                 w_we;
  logic [ADDR_SIZE-1:0] w_waddr;
  logic [WORD_SIZE-1:0] w_wdata;
  logic                 w_rd_en;
  logic                 w_wr_in_range;
  logic                 w_rd_in_range;
  logic [WORD_SIZE-1:0] w_rd_word;

  assign w_wr_in_range = ({1'b0, bus.wr_addr} < LP_DEPTH);
  assign w_rd_in_range = ({1'b0, bus.rd_addr} < LP_DEPTH);

  // State register and clear pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_CLEAR;
      r_clr_ptr <= {(ADDR_SIZE+1){1'b0}};
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_CLEAR) begin
        r_clr_ptr <= r_clr_ptr + LP_ONE;
      end else begin
        r_clr_ptr <= r_clr_ptr;
      end
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_CLEAR: begin
        if (r_clr_ptr == LP_LAST) begin
          w_state_nxt = ST_READY;
        end else begin
          w_state_nxt = ST_CLEAR;
        end
      end
      ST_READY: w_state_nxt = ST_READY;
      default:  w_state_nxt = ST_CLEAR;
    endcase
  end

  // Output decode: the single write port is shared between the clear sweep and user writes
  always_comb begin
    w_busy  = 1'b1;
    w_we    = 1'b0;
    w_waddr = r_clr_ptr[ADDR_SIZE-1:0];
    w_wdata = {WORD_SIZE{1'b0}};
    w_rd_en = 1'b0;
    case (r_state)
      ST_CLEAR: begin
        w_busy = 1'b1;
        w_we   = ~rst;
      end
      ST_READY: begin
        w_busy  = 1'b0;
        w_we    = ~rst & bus.cs & bus.wr & w_wr_in_range;
        w_waddr = bus.wr_addr;
        w_wdata = bus.data_in;
        w_rd_en = bus.cs & bus.rd;
      end
      default: begin
        w_busy = 1'b1;
        w_we   = 1'b0;
      end
    endcase
  end

  // Read data selection, including the optional forwarding path on a collision
  always_comb begin
    w_rd_word = {WORD_SIZE{1'b0}};
    if (!w_rd_in_range) begin
      w_rd_word = {WORD_SIZE{1'b0}};
    end else begin
`ifdef RAM_BYPASS_EN
      if (w_we && (w_waddr == bus.rd_addr)) begin
        w_rd_word = w_wdata;
      end else begin
        w_rd_word = r_mem[bus.rd_addr];
      end
`else
      w_rd_word = r_mem[bus.rd_addr];
`endif
    end
  end

  // Memory write port
  always_ff @(posedge clk) begin
    if (w_we) begin
      r_mem[w_waddr] <= w_wdata;
    end
  end

  // Registered read port and its valid strobe
  always_ff @(posedge clk) begin
    if (rst) begin
      r_data_out <= {WORD_SIZE{1'b0}};
      r_rd_valid <= 1'b0;
    end else if (w_rd_en) begin
      r_data_out <= w_rd_word;
      r_rd_valid <= 1'b1;
    end else begin
      r_data_out <= r_data_out;
      r_rd_valid <= 1'b0;
    end
  end

  assign bus.data_out = r_data_out;
  assign bus.rd_valid = r_rd_valid;
  assign bus.busy     = w_busy;
endmodule

// File: tb/tb_ram_sync_dp.sv
// Directed self-checking bench for ram_sync_dp: a 1024-word instance and a 1000-word
// instance for out-of-range addressing.
module tb_ram_sync_dp;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_tests = 0;
  int   n_fail  = 0;

  always #5 clk = ~clk;

  ram_sync_dp_if #(.ADDR_SIZE(10), .WORD_SIZE(8)) ifa ();
  ram_sync_dp_if #(.ADDR_SIZE(10), .WORD_SIZE(8)) ifb ();

  ram_sync_dp #(.ADDR_SIZE(10), .WORD_SIZE(8), .MEMORY_SIZE(1024)) dut_a (
    .clk(clk), .rst(rst), .bus(ifa)
  );
  ram_sync_dp #(.ADDR_SIZE(10), .WORD_SIZE(8), .MEMORY_SIZE(1000)) dut_b (
    .clk(clk), .rst(rst), .bus(ifb)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    ifa.cs = 1'b0; ifa.wr = 1'b0; ifa.rd = 1'b0;
    ifa.wr_addr = 10'd0; ifa.rd_addr = 10'd0; ifa.data_in = 8'd0;
    ifb.cs = 1'b0; ifb.wr = 1'b0; ifb.rd = 1'b0;
    ifb.wr_addr = 10'd0; ifb.rd_addr = 10'd0; ifb.data_in = 8'd0;
  endtask

  // Counts busy-high samples on both instances from the current point; bounded.
  task automatic count_busy(output int ca, output int cb, output bit saw_valid);
    ca = 0; cb = 0; saw_valid = 1'b0;
    for (int i = 0; i < 1200; i++) begin
      if (ifa.busy === 1'b1) ca++;
      if (ifb.busy === 1'b1) cb++;
      if (ifa.rd_valid !== 1'b0) saw_valid = 1'b1;
      if (ifa.busy === 1'b0 && ifb.busy === 1'b0) break;
      cyc();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    idle();
    repeat (3) cyc();
    n_tests++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_a got %b exp 1", ifa.busy); end
    n_tests++; if (ifa.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout_a got %h exp 00", ifa.data_out); end
    n_tests++; if (ifa.rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid_a got %b exp 0", ifa.rd_valid); end
    n_tests++; if (ifb.busy !== 1'b1) begin n_fail++; $display("FAIL reset_busy_b got %b exp 1", ifb.busy); end
    n_tests++; if (ifb.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_dout_b got %h exp 00", ifb.data_out); end
  endtask

  task automatic test_clear();
    int ca, cb;
    bit sv;
    logic [9:0] addrs [3];
    addrs[0] = 10'd0; addrs[1] = 10'd5; addrs[2] = 10'd1023;
    rst = 1'b0;
    count_busy(ca, cb, sv);
    n_tests++; if (ca != 1024) begin n_fail++; $display("FAIL clear_len_a got %0d exp 1024", ca); end
    n_tests++; if (cb != 1000) begin n_fail++; $display("FAIL clear_len_b got %0d exp 1000", cb); end
    for (int i = 0; i < 3; i++) begin
      ifa.cs = 1'b1; ifa.rd = 1'b1; ifa.rd_addr = addrs[i];
      cyc();
      n_tests++; if (ifa.rd_valid !== 1'b1) begin n_fail++; $display("FAIL clear_rd_valid[%0d] got %b exp 1", addrs[i], ifa.rd_valid); end
      n_tests++; if (ifa.data_out !== 8'h00) begin n_fail++; $display("FAIL clear_rd_data[%0d] got %h exp 00", addrs[i], ifa.data_out); end
      ifa.rd = 1'b0;
      cyc();
      n_tests++; if (ifa.rd_valid !== 1'b0) begin n_fail++; $display("FAIL clear_rd_idle[%0d] got %b exp 0", addrs[i], ifa.rd_valid); end
    end
  endtask

  task automatic test_chip_select();
    ifa.cs = 1'b0; ifa.wr = 1'b1; ifa.wr_addr = 10'd3; ifa.data_in = 8'h77;
    ifa.rd = 1'b1; ifa.rd_addr = 10'd3;
    cyc();
    n_tests++; if (ifa.rd_valid !== 1'b0) begin n_fail++; $display("FAIL cs_low_valid got %b exp 0", ifa.rd_valid); end
    ifa.cs = 1'b1; ifa.wr = 1'b0;
    cyc();
    n_tests++; if (ifa.data_out !== 8'h00) begin n_fail++; $display("FAIL cs_rd_data got %h exp 00", ifa.data_out); end
    n_tests++; if (ifa.rd_valid !== 1'b1) begin n_fail++; $display("FAIL cs_rd_valid got %b exp 1", ifa.rd_valid); end
    idle();
  endtask

  task automatic test_sweep();
    ifa.cs = 1'b1; ifa.wr = 1'b1; ifa.rd = 1'b0;
    for (int k = 0; k <= 16; k++) begin
      ifa.wr_addr = 10'(k); ifa.data_in = 8'(2 * k + 3);
      cyc();
    end
    ifa.wr = 1'b0; ifa.rd = 1'b1;
    for (int k = 0; k <= 16; k++) begin
      ifa.rd_addr = 10'(k);
      cyc();
      n_tests++; if (ifa.data_out !== 8'(2 * k + 3)) begin n_fail++; $display("FAIL sweep_data[%0d] got %h exp %h", k, ifa.data_out, 8'(2 * k + 3)); end
      n_tests++; if (ifa.rd_valid !== 1'b1) begin n_fail++; $display("FAIL sweep_valid[%0d] got %b exp 1", k, ifa.rd_valid); end
    end
    ifa.rd = 1'b0;
    cyc();
    n_tests++; if (ifa.rd_valid !== 1'b0) begin n_fail++; $display("FAIL sweep_valid_end got %b exp 0", ifa.rd_valid); end
    idle();
  endtask

  task automatic test_collision();
    logic [7:0] exp_col;
`ifdef RAM_BYPASS_EN
    exp_col = 8'hAA;
`else
    exp_col = 8'h11;
`endif
    ifa.cs = 1'b1; ifa.wr = 1'b1; ifa.wr_addr = 10'd7; ifa.data_in = 8'd17; ifa.rd = 1'b0;
    cyc();
    ifa.data_in = 8'hAA; ifa.rd = 1'b1; ifa.rd_addr = 10'd7;
    cyc();
    n_tests++; if (ifa.data_out !== exp_col) begin n_fail++; $display("FAIL collision_data got %h exp %h", ifa.data_out, exp_col); end
    n_tests++; if (ifa.rd_valid !== 1'b1) begin n_fail++; $display("FAIL collision_valid got %b exp 1", ifa.rd_valid); end
    ifa.wr = 1'b0;
    cyc();
    n_tests++; if (ifa.data_out !== 8'hAA) begin n_fail++; $display("FAIL collision_after got %h exp aa", ifa.data_out); end
    idle();
  endtask

  task automatic test_out_of_range();
    ifb.cs = 1'b1; ifb.wr = 1'b1; ifb.wr_addr = 10'd20; ifb.data_in = 8'h33; ifb.rd = 1'b0;
    cyc();
    ifb.wr = 1'b0; ifb.rd = 1'b1; ifb.rd_addr = 10'd20;
    cyc();
    n_tests++; if (ifb.data_out !== 8'h33) begin n_fail++; $display("FAIL oor_pre got %h exp 33", ifb.data_out); end
    ifb.wr = 1'b1; ifb.wr_addr = 10'd1010; ifb.data_in = 8'h55; ifb.rd = 1'b0;
    cyc();
    ifb.wr = 1'b0; ifb.rd = 1'b1; ifb.rd_addr = 10'd1010;
    cyc();
    n_tests++; if (ifb.data_out !== 8'h00) begin n_fail++; $display("FAIL oor_rd_data got %h exp 00", ifb.data_out); end
    n_tests++; if (ifb.rd_valid !== 1'b1) begin n_fail++; $display("FAIL oor_rd_valid got %b exp 1", ifb.rd_valid); end
    ifb.rd_addr = 10'd10;
    cyc();
    n_tests++; if (ifb.data_out !== 8'h00) begin n_fail++; $display("FAIL oor_alias_data got %h exp 00", ifb.data_out); end
    idle();
  endtask

  task automatic test_reset_mid_clear();
    int ca, cb;
    bit sv;
    rst = 1'b1;
    cyc();
    n_tests++; if (ifa.data_out !== 8'h00) begin n_fail++; $display("FAIL rerst_dout got %h exp 00", ifa.data_out); end
    rst = 1'b0;
    repeat (300) cyc();
    n_tests++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL midclr_busy got %b exp 1", ifa.busy); end
    rst = 1'b1;
    cyc();
    n_tests++; if (ifa.busy !== 1'b1) begin n_fail++; $display("FAIL midclr_rst_busy got %b exp 1", ifa.busy); end
    rst = 1'b0;
    ifa.cs = 1'b1; ifa.rd = 1'b1; ifa.rd_addr = 10'd7;
    count_busy(ca, cb, sv);
    n_tests++; if (ca != 1024) begin n_fail++; $display("FAIL midclr_len_a got %0d exp 1024", ca); end
    n_tests++; if (cb != 1000) begin n_fail++; $display("FAIL midclr_len_b got %0d exp 1000", cb); end
    n_tests++; if (sv !== 1'b0) begin n_fail++; $display("FAIL midclr_no_valid got %b exp 0", sv); end
    cyc();
    n_tests++; if (ifa.rd_valid !== 1'b1) begin n_fail++; $display("FAIL midclr_rd_valid got %b exp 1", ifa.rd_valid); end
    n_tests++; if (ifa.data_out !== 8'h00) begin n_fail++; $display("FAIL midclr_rd_data got %h exp 00", ifa.data_out); end
    idle();
  endtask

  initial begin
    test_reset();
    test_clear();
    test_chip_select();
    test_sweep();
    test_collision();
    test_out_of_range();
    test_reset_mid_clear();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog expired tests_run=%0d", n_tests);
    $fatal(1, "timeout");
  end
endmodule
